// File: rtl/shifting_piso.sv
// -----------------------------------------------------------------------------
// shifting_piso
//   Parallel-in / serial-out digit shifter for the code lock. A whole code word
//   is captured in one cycle and then emitted one digit per accepted transfer,
//   most significant digit first, under a valid/ready handshake.
//
// Parameters
//   DIGITS  digits per code word (>= 2)
//   DW      bits per digit
//
// Ports
//   clk      system clock, rising edge
//   clr      synchronous active-high reset
//   ce       clock enable; when low every register holds
//   load     capture request, honoured only while idle
//   data_i   parallel code word, digit 0 in the MSBs
//   ready_i  consumer accepts data_o this cycle
//   data_o   current digit (top digit of the shift register)
//   valid_o  data_o holds a valid digit
//   busy_o   word in progress
//   done_o   one-cycle pulse after the last digit was accepted
// -----------------------------------------------------------------------------

// One digit slot of the shift register. Slot DIGITS-1 is the output digit;
// each slot takes its lower neighbour on a shift.
module shifting_piso_slot #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          ce,
    input  logic          ld,     // capture parallel digit
    input  logic          sh,     // take neighbour digit
    input  logic          fl,     // flush to zero (word finished)
    input  logic [DW-1:0] d_ld,
    input  logic [DW-1:0] d_sh,
    output logic [DW-1:0] q
);
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (ce) begin
            if (fl)      q <= '0;
            else if (ld) q <= d_ld;
            else if (sh) q <= d_sh;
        end
    end
endmodule

module shifting_piso #(
    parameter int DIGITS = 4,
    parameter int DW     = 4
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 ce,
    input  logic                 load,
    input  logic [DIGITS*DW-1:0] data_i,
    input  logic                 ready_i,
    output logic [DW-1:0]        data_o,
    output logic                 valid_o,
    output logic                 busy_o,
    output logic                 done_o
);
    localparam int            CW   = $clog2(DIGITS);
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                     state;
    logic [CW-1:0]              cnt;
    logic [DIGITS-1:0][DW-1:0]  sr;
    logic [DIGITS-1:0][DW-1:0]  din;
    logic [DIGITS-1:0][DW-1:0]  sh_in;

    logic ld, xfer, last, sh, fl;

    // Index DIGITS-1 lands on the MSBs, so it is digit 0 of the word.
    assign din   = data_i;
    // Zero-filled one-digit shift toward the output slot.
    assign sh_in = sr << DW;

    assign ld    = (state == IDLE) & load;
    assign xfer  = valid_o & ready_i;
    assign last  = (cnt == LAST);
    assign sh    = xfer & ~last;
    assign fl    = xfer & last;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_slot
            shifting_piso_slot #(.DW(DW)) u_slot (
                .clk  (clk),
                .clr  (clr),
                .ce   (ce),
                .ld   (ld),
                .sh   (sh),
                .fl   (fl),
                .d_ld (din[g]),
                .d_sh (sh_in[g]),
                .q    (sr[g])
            );
        end
    endgenerate

    // sr is zero whenever idle, so the output view needs no extra masking.
    assign data_o = sr[DIGITS-1];

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            cnt     <= '0;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else if (ce) begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        state   <= SEND;
                        cnt     <= '0;
                        valid_o <= 1'b1;
                        busy_o  <= 1'b1;
                    end
                end
                SEND: begin
                    if (ready_i) begin
                        if (last) begin
                            state   <= IDLE;
                            cnt     <= '0;
                            valid_o <= 1'b0;
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
